// File: rtl/output_conditioner_if.sv
// Request/level bundle between core logic (master) and the output conditioner (slave).
interface output_conditioner_if;
  logic rise_req;
  logic fall_req;
  logic pin;
  logic rising;
  logic falling;
  logic busy;
  logic conflict;
  logic drop;

  modport master (
    output rise_req, fall_req,
    input  pin, rising, falling, busy, conflict, drop
  );

  modport slave (
    input  rise_req, fall_req,
    output pin, rising, falling, busy, conflict, drop
  );
endinterface

// File: rtl/output_conditioner.sv
// Turns one-cycle rise/fall requests into a pin level held at least HOLD cycles per transition.
// Define OUTCOND_PENDING_EN for a one-deep pending request buffer; otherwise blocked requests pulse drop.
module output_conditioner #(
  parameter int unsigned HOLD = 4
) (
  input  logic                clk,
  input  logic                reset,
  output_conditioner_if.slave bus
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);

  logic          pin_q, pin_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          rising_q, falling_q, conflict_q;
  logic          req, tgt;

`ifdef OUTCOND_PENDING_EN
  logic pv_q, pv_n;
  logic pt_q, pt_n;
`else
  logic drop_q, drop_n;
`endif

  always_comb begin
    req   = bus.rise_req ^ bus.fall_req;
    tgt   = bus.rise_req;
    pin_n = pin_q;
    cnt_n = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
`ifdef OUTCOND_PENDING_EN
    pv_n  = pv_q;
    pt_n  = pt_q;
    if (cnt_q == '0 && !pv_q) begin
      if (req && tgt != pin_q) begin
        pin_n = tgt;
        cnt_n = CNT_LOAD;
      end
    end else begin
      if (cnt_q == '0) begin
        pin_n = pt_q;
        cnt_n = CNT_LOAD;
        pv_n  = 1'b0;
      end
      // Compared against pin_n so a request in the drain cycle sees the new level.
      if (req) begin
        if (tgt != pin_n) begin
          pv_n = 1'b1;
          pt_n = tgt;
        end else begin
          pv_n = 1'b0;
        end
      end
    end
`else
    drop_n = 1'b0;
    if (req && tgt != pin_q) begin
      if (cnt_q == '0) begin
        pin_n = tgt;
        cnt_n = CNT_LOAD;
      end else begin
        drop_n = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pin_q      <= 1'b0;
      cnt_q      <= '0;
      rising_q   <= 1'b0;
      falling_q  <= 1'b0;
      conflict_q <= 1'b0;
`ifdef OUTCOND_PENDING_EN
      pv_q       <= 1'b0;
      pt_q       <= 1'b0;
`else
      drop_q     <= 1'b0;
`endif
    end else begin
      pin_q      <= pin_n;
      cnt_q      <= cnt_n;
      rising_q   <= pin_n & ~pin_q;
      falling_q  <= ~pin_n & pin_q;
      conflict_q <= bus.rise_req & bus.fall_req;
`ifdef OUTCOND_PENDING_EN
      pv_q       <= pv_n;
      pt_q       <= pt_n;
`else
      drop_q     <= drop_n;
`endif
    end
  end

  assign bus.pin      = pin_q;
  assign bus.rising   = rising_q;
  assign bus.falling  = falling_q;
  assign bus.conflict = conflict_q;
`ifdef OUTCOND_PENDING_EN
  assign bus.busy     = (cnt_q != '0) | pv_q;
  assign bus.drop     = 1'b0;
`else
  assign bus.busy     = (cnt_q != '0);
  assign bus.drop     = drop_q;
`endif

endmodule

// File: tb/tb_output_conditioner.sv
// Scenario bench for output_conditioner (HOLD=4); expected output vectors are hand-derived per cycle.
module tb_output_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned total = 0;
  int unsigned passed = 0;
  logic [5:0] exp_q[$];

  output_conditioner_if bus();

  output_conditioner #(.HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stimulus code {reset, rise_req, fall_req}; expected {pin, rising, falling, busy, conflict, drop}.
  localparam logic [2:0] I = 3'b000, R = 3'b010, F = 3'b001, B = 3'b011, X = 3'b100, XR = 3'b110;

  function automatic logic [5:0] outs();
    return {bus.pin, bus.rising, bus.falling, bus.busy, bus.conflict, bus.drop};
  endfunction

  task automatic drive(input logic [2:0] s);
    reset        = s[2];
    bus.rise_req = s[1];
    bus.fall_req = s[0];
  endtask

  task automatic test_reset();
    logic [2:0] stim [12] = '{X, X, I, I, I, I, I, I, I, I, I, I};
    logic [5:0] got, want;
    foreach (stim[i]) begin
      drive(stim[i]);
      exp_q.push_back(6'b000000);
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL reset[%0d] got=%b want=%b", i, got, want);
      else passed++;
    end
  endtask

  task automatic test_basic_edges();
    logic [2:0] stim [11] = '{F, R, I, I, I, I, R, F, I, I, I};
    logic [5:0] ev [11] = '{6'b000000, 6'b110100, 6'b100100, 6'b100100, 6'b100000, 6'b100000,
                            6'b100000, 6'b001100, 6'b000100, 6'b000100, 6'b000000};
    logic [5:0] got, want;
    foreach (stim[i]) begin
      drive(stim[i]);
      exp_q.push_back(ev[i]);
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL basic_edges[%0d] got=%b want=%b", i, got, want);
      else passed++;
    end
  endtask

  task automatic test_pending_or_drop();
`ifdef OUTCOND_PENDING_EN
    logic [2:0] stim [8] = '{R, F, I, I, I, I, I, I};
    logic [5:0] ev [8] = '{6'b110100, 6'b100100, 6'b100100, 6'b100100,
                           6'b001100, 6'b000100, 6'b000100, 6'b000000};
`else
    logic [2:0] stim [9] = '{R, F, I, I, I, F, I, I, I};
    logic [5:0] ev [9] = '{6'b110100, 6'b100101, 6'b100100, 6'b100000, 6'b100000,
                           6'b001100, 6'b000100, 6'b000100, 6'b000000};
`endif
    logic [5:0] got, want;
    foreach (stim[i]) begin
      drive(stim[i]);
      exp_q.push_back(ev[i]);
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL pending_or_drop[%0d] got=%b want=%b", i, got, want);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    logic [2:0] stim [9] = '{R, F, R, I, I, F, I, I, I};
`ifdef OUTCOND_PENDING_EN
    logic [5:0] ev [9] = '{6'b110100, 6'b100100, 6'b100100, 6'b100000, 6'b100000,
                           6'b001100, 6'b000100, 6'b000100, 6'b000000};
`else
    logic [5:0] ev [9] = '{6'b110100, 6'b100101, 6'b100100, 6'b100000, 6'b100000,
                           6'b001100, 6'b000100, 6'b000100, 6'b000000};
`endif
    logic [5:0] got, want;
    foreach (stim[i]) begin
      drive(stim[i]);
      exp_q.push_back(ev[i]);
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL glitch[%0d] got=%b want=%b", i, got, want);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
`ifdef OUTCOND_PENDING_EN
    logic [2:0] stim [16] = '{R, F, I, I, R, I, I, I, I, I, I, I, F, I, I, I};
    logic [5:0] ev [16] = '{6'b110100, 6'b100100, 6'b100100, 6'b100100,
                            6'b001100, 6'b000100, 6'b000100, 6'b000100,
                            6'b110100, 6'b100100, 6'b100100, 6'b100000,
                            6'b001100, 6'b000100, 6'b000100, 6'b000000};
`else
    logic [2:0] stim [8] = '{R, F, F, F, F, I, I, I};
    logic [5:0] ev [8] = '{6'b110100, 6'b100101, 6'b100101, 6'b100001,
                           6'b001100, 6'b000100, 6'b000100, 6'b000000};
`endif
    logic [5:0] got, want;
    foreach (stim[i]) begin
      drive(stim[i]);
      exp_q.push_back(ev[i]);
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL back_to_back[%0d] got=%b want=%b", i, got, want);
      else passed++;
    end
  endtask

  task automatic test_conflict();
    logic [2:0] stim [9] = '{B, R, B, I, I, F, I, I, I};
    logic [5:0] ev [9] = '{6'b000010, 6'b110100, 6'b100110, 6'b100100, 6'b100000,
                           6'b001100, 6'b000100, 6'b000100, 6'b000000};
    logic [5:0] got, want;
    foreach (stim[i]) begin
      drive(stim[i]);
      exp_q.push_back(ev[i]);
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL conflict[%0d] got=%b want=%b", i, got, want);
      else passed++;
    end
  endtask

  task automatic test_reset_pending();
    logic [2:0] stim [9] = '{R, F, XR, I, I, I, I, I, I};
`ifdef OUTCOND_PENDING_EN
    logic [5:0] ev [9] = '{6'b110100, 6'b100100, 6'b000000, 6'b000000, 6'b000000,
                           6'b000000, 6'b000000, 6'b000000, 6'b000000};
`else
    logic [5:0] ev [9] = '{6'b110100, 6'b100101, 6'b000000, 6'b000000, 6'b000000,
                           6'b000000, 6'b000000, 6'b000000, 6'b000000};
`endif
    logic [5:0] got, want;
    foreach (stim[i]) begin
      drive(stim[i]);
      exp_q.push_back(ev[i]);
      @(posedge clk); #1;
      got = outs(); want = exp_q.pop_front(); total++;
      if (got !== want) $display("FAIL reset_pending[%0d] got=%b want=%b", i, got, want);
      else passed++;
    end
  endtask

  initial begin
    drive(X);
    test_reset();
    test_basic_edges();
    test_pending_or_drop();
    test_glitch();
    test_back_to_back();
    test_conflict();
    test_reset_pending();
    drive(I);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
